// File: rtl/serial_add16_arbiter.sv
// serial_add16_arbiter
//   Two-requester 16-bit adder. A round-robin arbiter grants one requester
//   at a time. Its operands are captured, then added one nibble per cycle
//   through a single 4-bit ripple adder. The 17-bit result is published only
//   once it is complete.
//
// Ports
//   clk             : clock; all state updates on its rising edge
//   rst             : asynchronous active-high reset
//   req0 / req1     : operation request, held until the matching ack
//   a0, b0 / a1, b1 : 16-bit operands per requester
//   cin0 / cin1     : carry-in per requester
//   ack0 / ack1     : one-cycle pulse after the grant edge (operands captured)
//   busy            : high whenever the FSM is not idle
//   sum, cout       : result of the last completed operation
//   done            : one-cycle pulse; sum/cout/done_id have just updated
//   done_id         : requester index of the last completed operation

// FullAdder_4
//   4-bit ripple-carry adder.
// Ports
//   a, b : 4-bit addends
//   cin  : carry-in
//   sum  : 4-bit sum
//   cout : carry-out of bit 3
module FullAdder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

module serial_add16_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        cin0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        cin1,
    output logic        ack0,
    output logic        ack1,
    output logic        busy,
    output logic [15:0] sum,
    output logic        cout,
    output logic        done,
    output logic        done_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;

    logic        grant;   // grant happens at this edge
    logic        gsel;    // index of the requester being granted
    logic        prio;    // 1: requester 1 wins a tie, 0: requester 0 wins

    logic [15:0] op_a, op_b;
    logic [15:0] res;     // partial result, nibbles filled low to high
    logic        carry;
    logic [1:0]  nib;
    logic        gid;     // index of the operation in flight

    logic [3:0]  fa_a, fa_b, fa_s;
    logic        fa_c;

    // Select the current nibble of each captured operand.
    assign fa_a = op_a[{nib, 2'b00} +: 4];
    assign fa_b = op_b[{nib, 2'b00} +: 4];

    FullAdder_4 u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        gsel    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    // On a tie, serve whichever requester was not served last.
                    gsel    = (req0 && req1) ? prio : req1;
                    state_n = ADD;
                end
            end
            ADD: begin
                if (nib == 2'd3) state_n = DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            nib     <= '0;
            gid     <= 1'b0;
            prio    <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            if (grant) begin
                op_a  <= gsel ? a1 : a0;
                op_b  <= gsel ? b1 : b0;
                carry <= gsel ? cin1 : cin0;
                nib   <= '0;
                gid   <= gsel;
                prio  <= ~gsel;
                ack0  <= ~gsel;
                ack1  <= gsel;
            end
            if (state == ADD) begin
                res[{nib, 2'b00} +: 4] <= fa_s;
                carry                  <= fa_c;
                nib                    <= nib + 2'd1;
                // The top nibble goes straight into sum, so sum never exposes a partial value.
                if (nib == 2'd3) begin
                    sum     <= {fa_s, res[11:0]};
                    cout    <= fa_c;
                    done_id <= gid;
                end
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add16_arbiter.sv
module tb_serial_add16_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        cin0, cin1;
    logic        ack0, ack1, busy, cout, done, done_id;
    logic [15:0] sum;

    serial_add16_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .a0      (a0),
        .b0      (b0),
        .cin0    (cin0),
        .a1      (a1),
        .b1      (b1),
        .cin1    (cin1),
        .ack0    (ack0),
        .ack1    (ack1),
        .busy    (busy),
        .sum     (sum),
        .cout    (cout),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        id;
        logic [15:0] s;
        logic        c;
    } exp_t;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] es;
        logic        ec;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] held_sum  = '0;
    logic        held_cout = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pops one expected result; outputs must hold between dones.
    always @(negedge clk) begin
        if (rst) begin
            held_sum  = '0;
            held_cout = 1'b0;
        end else if (done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done_unexpected: got done=1 expected no pending operation at %0t", $time);
            end else begin
                e = sb.pop_front();
                chk("sum", {16'h0, sum}, {16'h0, e.s});
                chk("cout", {31'h0, cout}, {31'h0, e.c});
                chk("done_id", {31'h0, done_id}, {31'h0, e.id});
                held_sum  = e.s;
                held_cout = e.c;
            end
        end else if (busy) begin
            chk("sum_hold", {16'h0, sum}, {16'h0, held_sum});
            chk("cout_hold", {31'h0, cout}, {31'h0, held_cout});
        end
    end

    task automatic drive(input logic id, input logic [15:0] a, input logic [15:0] b, input logic c);
        if (id) begin
            a1 = a; b1 = b; cin1 = c; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; cin0 = c; req0 = 1'b1;
        end
    endtask

    task automatic wait_ack(input logic id, input int limit, output int waited);
        waited = -1;
        for (int n = 1; n <= limit; n++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                chk("ack_pair", {30'h0, ack1, ack0}, id ? 32'h2 : 32'h1);
                waited = n;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL ack_timeout: got no ack%0d expected ack within %0d cycles", id, limit);
    endtask

    task automatic run_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [15:0] es, input logic ec);
        int w;
        int dn;
        drive(id, a, b, c);
        wait_ack(id, 1, w);
        chk("ack_latency", w, 1);
        sb.push_back('{id, es, ec});
        req0 = 1'b0;
        req1 = 1'b0;
        dn = -1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (done) begin
                dn = n;
                break;
            end
        end
        chk("done_latency", dn, 4);
        @(negedge clk);
        chk("busy_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1, "watchdog");
    end

    vec_t vt[9];

    initial begin
        int w;
        logic [16:0] m;
        logic [15:0] ra, rb;
        logic        rc, rid;

        vt[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vt[1] = '{1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vt[2] = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vt[3] = '{1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vt[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[5] = '{1'b1, 16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vt[6] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vt[7] = '{1'b1, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
        vt[8] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; cin0 = 1'b0;
        a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum", {16'h0, sum}, 32'h0);
        chk("rst_cout", {31'h0, cout}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_acks", {30'h0, ack1, ack0}, 32'h0);
        chk("rst_done_id", {31'h0, done_id}, 32'h0);
        rst = 1'b0;

        // Table-driven single operations.
        for (int i = 0; i < 9; i++)
            run_op(vt[i].id, vt[i].a, vt[i].b, vt[i].cin, vt[i].es, vt[i].ec);

        // Random operands against a 17-bit reference sum.
        for (int i = 0; i < 4; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            rid = 1'($urandom);
            m   = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
            run_op(rid, ra, rb, rc, m[15:0], m[16]);
        end

        // Contention from reset: both held, service alternates 0,1,0,1 six cycles apart.
        rst = 1'b1;
        a0 = 16'h1111; b0 = 16'h2222; cin0 = 1'b0;
        a1 = 16'h00F0; b1 = 16'h0F10; cin1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(k[0], 8, w);
            chk("contend_spacing", w, (k == 0) ? 1 : 6);
            if (k[0]) sb.push_back('{1'b1, 16'h1001, 1'b0});
            else      sb.push_back('{1'b0, 16'h3333, 1'b0});
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (6) @(negedge clk);
        chk("contend_drained", sb.size(), 0);

        // Abort during the second ADD cycle: asynchronous clear, no done.
        drive(1'b0, 16'h1234, 16'h1111, 1'b0);
        wait_ack(1'b0, 1, w);
        req0 = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_sum", {16'h0, sum}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_done_id", {31'h0, done_id}, 32'h0);
        chk("abort_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        run_op(1'b1, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        // Hold-off: req0 raised while req1 is in service is granted at E6.
        drive(1'b1, 16'h0F0F, 16'h0101, 1'b0);
        wait_ack(1'b1, 1, w);
        sb.push_back('{1'b1, 16'h1010, 1'b0});
        req1 = 1'b0;
        @(negedge clk);
        drive(1'b0, 16'h2222, 16'hDDDD, 1'b1);
        wait_ack(1'b0, 10, w);
        chk("holdoff_ack0_delay", w, 5);
        sb.push_back('{1'b0, 16'h0000, 1'b1});
        req0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("holdoff_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
